// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the LEGv8 core: walks each instruction through
// fetch/decode/execute/memory/writeback, issues one-cycle enables, and traps on faults.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    input  logic                   halt,
    input  logic [10:0]            opcode,
    input  logic                   zero_flag,
    input  logic                   imem_ready,
    input  logic                   dmem_ready,
    output logic                   imem_req,
    output logic                   ir_write,
    output logic                   ControlWire,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic                   reg_write_en,
    output logic                   pc_write,
    output logic                   pc_src,
    output logic [2:0]             state,
    output logic [1:0]             trap_cause,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        C_B,
        C_CBZ,
        C_LDUR,
        C_STUR,
        C_RTYPE,
        C_ILLEGAL
    } class_e;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // The counter holds completed wait cycles; it never needs to exceed MEM_TIMEOUT-1.
    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e                 state_q, state_d;
    class_e                 class_q, class_d;
    class_e                 dec_class;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [1:0]             trap_q, trap_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    // B and CBZ carry immediate bits inside the opcode field, so they are matched first.
    always_comb begin
        dec_class = C_ILLEGAL;
        if (opcode[10:5] == 6'b000101) begin
            dec_class = C_B;
        end else if (opcode[10:3] == 8'b10110100) begin
            dec_class = C_CBZ;
        end else begin
            case (opcode)
                11'b11111000010: dec_class = C_LDUR;
                11'b11111000000: dec_class = C_STUR;
                11'b10001011000,
                11'b11001011000,
                11'b10001010000,
                11'b10101010000: dec_class = C_RTYPE;
                default:         dec_class = C_ILLEGAL;
            endcase
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned and infers a latch.
        state_d      = state_q;
        class_d      = class_q;
        wait_d       = '0;
        trap_d       = trap_q;
        count_d      = count_q;
        imem_req     = 1'b0;
        ir_write     = 1'b0;
        ControlWire  = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        reg_write_en = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!halt) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    trap_d  = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                ControlWire = 1'b1;
                class_d     = dec_class;
                if (dec_class == C_ILLEGAL) begin
                    state_d = S_TRAP;
                    trap_d  = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                ControlWire = 1'b1;
                case (class_q)
                    C_B: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                    end
                    C_CBZ: begin
                        pc_write = 1'b1;
                        pc_src   = zero_flag;
                    end
                    C_LDUR, C_STUR: state_d = S_MEM;
                    default:        state_d = S_WB;
                endcase
            end
            S_MEM: begin
                ControlWire = 1'b1;
                dmem_req    = 1'b1;
                dmem_we     = (class_q == C_STUR);
                if (dmem_ready) begin
                    if (class_q == C_STUR) pc_write = 1'b1;
                    else                   state_d  = S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    trap_d  = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                ControlWire  = 1'b1;
                reg_write_en = 1'b1;
                pc_write     = 1'b1;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every pc_write marks an instruction boundary, where halt is honoured.
        if (pc_write) begin
            count_d = count_q + 1'b1;
            state_d = halt ? S_IDLE : S_FETCH;
        end
    end

    always_ff @(posedge CLOCK) begin
        // NOTE: state registers use non-blocking assignments so all of them update together from pre-edge values.
        if (RESET) begin
            state_q <= S_IDLE;
            class_q <= C_ILLEGAL;
            wait_q  <= '0;
            trap_q  <= 2'b00;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            wait_q  <= wait_d;
            trap_q  <= trap_d;
            count_q <= count_d;
        end
    end

    assign state       = state_q;
    assign trap_cause  = trap_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: each instruction is planned as a transaction (opcode, memory
// wait counts, halt at retire) and expanded into the per-cycle output trace it must produce.
module tb_multicycle_sequencer;

    localparam int TMO = 4;
    localparam int CB = 0, CCBZ = 1, CLD = 2, CST = 3, CR = 4, CILL = 5;
    localparam logic [10:0] R_OPS [4] = '{11'b10001011000, 11'b11001011000,
                                          11'b10001010000, 11'b10101010000};

    logic        CLOCK = 1'b0;
    logic        RESET, halt, zero_flag, imem_ready, dmem_ready;
    logic [10:0] opcode;
    logic        imem_req, ir_write, ControlWire, dmem_req, dmem_we;
    logic        reg_write_en, pc_write, pc_src;
    logic [2:0]  state;
    logic [1:0]  trap_cause;
    logic [31:0] instr_count;

    always #5 CLOCK = ~CLOCK;

    multicycle_sequencer #(.MEM_TIMEOUT(TMO), .COUNT_WIDTH(32)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .halt(halt), .opcode(opcode), .zero_flag(zero_flag),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
        .ir_write(ir_write), .ControlWire(ControlWire), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .reg_write_en(reg_write_en), .pc_write(pc_write),
        .pc_src(pc_src), .state(state), .trap_cause(trap_cause), .instr_count(instr_count)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] tc;
        logic imem_req, ir_write, cw, dreq, dwe, rwe, pcw, pcs;
    } obs_t;

    obs_t obs;
    assign obs = {state, trap_cause, imem_req, ir_write, ControlWire, dmem_req, dmem_we,
                  reg_write_en, pc_write, pc_src};

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_count;
    logic [1:0]  exp_trap;
    bit          in_idle;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, got, want, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic int classify(input logic [10:0] op);
        if (op[10:5] == 6'b000101)   return CB;
        if (op[10:3] == 8'b10110100) return CCBZ;
        if (op == 11'b11111000010)   return CLD;
        if (op == 11'b11111000000)   return CST;
        foreach (R_OPS[i]) if (op == R_OPS[i]) return CR;
        return CILL;
    endfunction

    function automatic logic [10:0] make_op(input int cls);
        logic [10:0] op;
        case (cls)
            CB:      op = {6'b000101, 5'($urandom)};
            CCBZ:    op = {8'b10110100, 3'($urandom)};
            CLD:     op = 11'b11111000010;
            CST:     op = 11'b11111000000;
            CR:      op = R_OPS[$urandom_range(0, 3)];
            default: begin
                do op = 11'($urandom); while (classify(op) != CILL);
            end
        endcase
        return op;
    endfunction

    // Expected outputs for a plain visit to a state; ControlWire covers DECODE..WB.
    function automatic obs_t base(input logic [2:0] st);
        obs_t e;
        e    = '0;
        e.st = st;
        e.tc = exp_trap;
        e.cw = (st >= 3'd2 && st <= 3'd5);
        return e;
    endfunction

    // One clock cycle: drive at posedge+1, compare at the falling edge.
    task automatic cyc(input string tag, input logic ir, input logic dr, input logic h,
                       input logic z, input obs_t e);
        imem_ready = ir;
        dmem_ready = dr;
        halt       = h;
        zero_flag  = z;
        @(negedge CLOCK);
        check(tag, 64'(obs), 64'(e));
        check({tag, "/count"}, 64'(instr_count), 64'(exp_count));
        @(posedge CLOCK);
        #1;
    endtask

    task automatic retire(input string tag, input logic ir, input logic dr, input logic h,
                          input logic z, input obs_t e);
        cyc(tag, ir, dr, h, z, e);
        exp_count++;
        in_idle = h;
    endtask

    task automatic do_reset(input string tag, input obs_t e);
        RESET = 1'b1;
        cyc(tag, 1'b0, 1'b0, rb(), rb(), e);
        RESET     = 1'b0;
        exp_count = '0;
        exp_trap  = 2'b00;
        in_idle   = 1'b1;
    endtask

    task automatic trap_and_reset(input logic [1:0] cause, input int hold);
        exp_trap = cause;
        for (int i = 0; i < hold; i++) cyc("trap", rb(), rb(), rb(), rb(), base(3'd7));
        do_reset("trap-rst", base(3'd7));
    endtask

    // fw/mw: ready arrives on the request cycle with that 0-based index.
    task automatic run_instr(input logic [10:0] op, input int fw, input int mw,
                             input logic hret, input int zsel, input int rst_mem,
                             input int hold);
        int   cls;
        int   n_halt;
        obs_t e;
        logic z;
        logic rdy;
        logic got;
        cls    = classify(op);
        opcode = op;
        if (in_idle) begin
            n_halt = $urandom_range(0, 2);
            for (int i = 0; i < n_halt; i++) cyc("idle-halt", rb(), rb(), 1'b1, rb(), base(3'd0));
            cyc("idle", rb(), rb(), 1'b0, rb(), base(3'd0));
        end
        got = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            rdy        = (k == fw);
            e          = base(3'd1);
            e.imem_req = 1'b1;
            e.ir_write = rdy;
            cyc("fetch", rdy, rb(), rb(), rb(), e);
            if (rdy) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            trap_and_reset(2'b10, hold);
            return;
        end
        cyc("decode", rb(), rb(), rb(), rb(), base(3'd2));
        if (cls == CILL) begin
            trap_and_reset(2'b01, hold);
            return;
        end
        z = (zsel == 2) ? rb() : zsel[0];
        e = base(3'd3);
        if (cls == CB || cls == CCBZ) begin
            e.pcw = 1'b1;
            e.pcs = (cls == CB) ? 1'b1 : z;
            retire("exec-br", rb(), rb(), hret, z, e);
            return;
        end
        cyc("exec", rb(), rb(), rb(), z, e);
        if (cls == CLD || cls == CST) begin
            got = 1'b0;
            for (int k = 0; k < TMO; k++) begin
                e      = base(3'd4);
                e.dreq = 1'b1;
                e.dwe  = (cls == CST);
                if (k == rst_mem) begin
                    do_reset("mem-rst", e);
                    return;
                end
                rdy = (k == mw);
                if (rdy && cls == CST) begin
                    e.pcw = 1'b1;
                    retire("mem-st", rb(), 1'b1, hret, rb(), e);
                    return;
                end
                cyc("mem", rb(), rdy, rb(), rb(), e);
                if (rdy) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                trap_and_reset(2'b10, hold);
                return;
            end
        end
        e     = base(3'd5);
        e.rwe = 1'b1;
        e.pcw = 1'b1;
        retire("wb", rb(), rb(), hret, rb(), e);
    endtask

    initial begin
        int cls;
        int fw;
        int mw;
        RESET      = 1'b1;
        halt       = 1'b0;
        opcode     = '0;
        zero_flag  = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        repeat (2) @(posedge CLOCK);
        #1;
        RESET     = 1'b0;
        exp_count = '0;
        exp_trap  = 2'b00;
        in_idle   = 1'b1;

        // ADD with zero-wait memories, then LDUR with a 3-cycle data wait.
        run_instr(11'b10001011000, 0, 0, 1'b0, 2, -1, 3);
        run_instr(11'b11111000010, 0, 3, 1'b0, 2, -1, 3);
        // CBZ taken then not taken.
        run_instr(make_op(CCBZ), 0, 0, 1'b0, 1, -1, 3);
        run_instr(make_op(CCBZ), 0, 0, 1'b0, 0, -1, 3);
        // Illegal opcode held in TRAP for 20 cycles, then reset.
        run_instr(11'b00000000000, 0, 0, 1'b0, 2, -1, 20);
        // Fetch ready on the last allowed cycle, then a fetch that never gets ready.
        run_instr(make_op(CB), TMO - 1, 0, 1'b0, 2, -1, 3);
        run_instr(make_op(CB), TMO, 0, 1'b0, 2, -1, 3);
        // Data-side timeout boundary both ways.
        run_instr(11'b11111000000, 0, TMO - 1, 1'b0, 2, -1, 3);
        run_instr(11'b11111000010, 0, TMO, 1'b0, 2, -1, 3);
        // STUR halting at retire, restart from IDLE, then reset during a MEM wait.
        run_instr(11'b11111000000, 0, 2, 1'b1, 2, -1, 3);
        run_instr(11'b11111000000, 0, 3, 1'b0, 2, 1, 3);
        run_instr(R_OPS[3], 0, 0, 1'b0, 2, -1, 3);

        for (int n = 0; n < 80; n++) begin
            cls = $urandom_range(0, 5);
            if (cls == CILL && rb()) cls = CR;
            fw = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO - 1, TMO + 1) : $urandom_range(0, 2);
            mw = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO - 1, TMO + 1) : $urandom_range(0, 2);
            run_instr(make_op(cls), fw, mw, ($urandom_range(0, 3) == 0), 2, -1,
                      $urandom_range(1, 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
